load_unit: RTL and testbench

LOAD_UNIT -- requirements
Module: load_unit

---
 rtl/rv32i_types.sv | 42 ++++
 rtl/load_align.sv | 45 ++++
 rtl/load_unit.sv | 142 ++++++++++++++
 tb/tb_load_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared RV32I load-path types: upstream FIFO and CDB packets, load funct3 encodings,
// load FSM states and the misalignment helper.
package rv32i_types;

    localparam int unsigned DataW   = 32;
    localparam int unsigned PAddrW  = 6;
    localparam int unsigned RobIdxW = 5;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    typedef struct packed {
        logic               ready;
        logic [PAddrW-1:0]  rs1_paddr;
        logic [PAddrW-1:0]  rd_paddr;
        logic [RobIdxW-1:0] rob_idx;
        logic [2:0]         funct3;
        logic [11:0]        imm;
    } ld_st_data_pkt_t;

    typedef struct packed {
        logic               cdb_broadcast;
        logic [PAddrW-1:0]  cdb_p_addr;
        logic [DataW-1:0]   data;
        logic [RobIdxW-1:0] rob_idx;
        logic               exc;
    } cdb_pkt_t;

    typedef enum logic [1:0] {StIdle, StReq, StWait, StBcast} load_state_t;

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
        case (funct3)
            F3Lh, F3Lhu: return offset[0];
            F3Lw:        return offset != 2'b00;
            default:     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational byte-lane logic for loads: read mask from funct3/offset, and
// shift plus sign/zero extension of the returned memory word.
module load_align import rv32i_types::*; #(
    parameter int unsigned XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] result,
    output logic [3:0]      rmask
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        result  = shifted;
        rmask   = 4'b0000;
        // Masks shift out of the word on misaligned accesses, leaving a truncated mask.
        case (funct3)
            F3Lb: begin
                rmask  = 4'b0001 << offset;
                result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            end
            F3Lbu: begin
                rmask  = 4'b0001 << offset;
                result = {{(XLEN-8){1'b0}}, shifted[7:0]};
            end
            F3Lh: begin
                rmask  = 4'b0011 << offset;
                result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            end
            F3Lhu: begin
                rmask  = 4'b0011 << offset;
                result = {{(XLEN-16){1'b0}}, shifted[15:0]};
            end
            F3Lw: begin
                rmask  = 4'b1111 << offset;
                result = shifted;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_unit.sv
// Load unit: pops a ready load, issues one dmem read, aligns the reply and broadcasts it on the CDB.
// Optional LOAD_MISALIGN_CHECK_EN: misaligned LH/LHU/LW skip memory and broadcast with exc set.
module load_unit import rv32i_types::*; #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  ld_st_data_pkt_t   ld_head,
    input  logic              ld_empty,
    output logic              ld_ren,
    output logic [PAddrW-1:0] prf_rs1_paddr,
    input  logic [XLEN-1:0]   prf_rs1_rdata,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_rmask,
    input  logic [XLEN-1:0]   dmem_rdata,
    input  logic              dmem_resp,
    output logic              cdb_req,
    input  logic              cdb_gnt,
    output cdb_pkt_t          cdb_out,
    input  logic              flush,
    output logic              busy
);

    load_state_t        state_q, state_d;
    logic [XLEN-1:0]    addr_q, addr_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [PAddrW-1:0]  rd_q, rd_d;
    logic [RobIdxW-1:0] rob_q, rob_d;
    logic               drain_q, drain_d;
    logic               exc_q, exc_d;
    logic [XLEN-1:0]    ld_addr;
    logic [XLEN-1:0]    align_result;
    logic [3:0]         align_mask;
    logic               misaligned;

    assign ld_addr = prf_rs1_rdata + {{(XLEN-12){ld_head.imm[11]}}, ld_head.imm};

`ifdef LOAD_MISALIGN_CHECK_EN
    assign misaligned = is_misaligned(ld_head.funct3, ld_addr[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .funct3(funct3_q),
        .offset(addr_q[1:0]),
        .rdata (dmem_rdata),
        .result(align_result),
        .rmask (align_mask)
    );

    assign prf_rs1_paddr = ld_head.rs1_paddr;
    assign dmem_addr     = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_rmask    = (state_q == StReq) ? align_mask : 4'b0000;
    assign busy          = state_q != StIdle;
    assign cdb_req       = (state_q == StBcast) && !flush;

    always_comb begin
        cdb_out               = '0;
        cdb_out.cdb_broadcast = cdb_req && cdb_gnt;
        cdb_out.cdb_p_addr    = rd_q;
        cdb_out.data          = result_q;
        cdb_out.rob_idx       = rob_q;
        cdb_out.exc           = exc_q;
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        result_d = result_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        rob_d    = rob_q;
        drain_d  = drain_q;
        exc_d    = exc_q;
        ld_ren   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!rst && !ld_empty && ld_head.ready && !flush) begin
                    ld_ren   = 1'b1;
                    addr_d   = ld_addr;
                    funct3_d = ld_head.funct3;
                    rd_d     = ld_head.rd_paddr;
                    rob_d    = ld_head.rob_idx;
                    result_d = '0;
                    drain_d  = 1'b0;
                    exc_d    = misaligned;
                    state_d  = misaligned ? StBcast : StReq;
                end
            end
            StReq: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (dmem_resp) begin
                    result_d = align_result;
                    state_d  = (rd_q == '0) ? StIdle : StBcast;
                end else begin
                    state_d = StWait;
                end
            end
            StWait: begin
                // A flushed access stays here until its response drains so it cannot alias a new load.
                if (dmem_resp) begin
                    result_d = align_result;
                    state_d  = (drain_q || flush || rd_q == '0) ? StIdle : StBcast;
                end else if (flush) begin
                    drain_d = 1'b1;
                end
            end
            StBcast: begin
                if (flush || cdb_gnt) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            result_q <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            rob_q    <= '0;
            drain_q  <= 1'b0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            result_q <= result_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            rob_q    <= rob_d;
            drain_q  <= drain_d;
            exc_q    <= exc_d;
        end
    end

endmodule

// File: tb/tb_load_unit.sv
// Self-checking bench for load_unit: directed scenarios plus randomized loads against a
// per-transaction reference model (address, byte mask, extended data, timing).
module tb_load_unit;
    import rv32i_types::*;

    logic            clk = 1'b0;
    logic            rst;
    ld_st_data_pkt_t ld_head;
    logic            ld_empty, ld_ren;
    logic [5:0]      prf_rs1_paddr;
    logic [31:0]     prf_rs1_rdata, dmem_addr, dmem_rdata;
    logic [3:0]      dmem_rmask;
    logic            dmem_resp, cdb_req, cdb_gnt, flush, busy;
    cdb_pkt_t        cdb_out;

    logic [31:0] regfile [64];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_data, last_addr;
    logic [3:0]  last_mask;
    cdb_pkt_t    last_pkt;

    assign prf_rs1_rdata = regfile[prf_rs1_paddr];

    always #5 clk = ~clk;

    load_unit #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_head      (ld_head),
        .ld_empty     (ld_empty),
        .ld_ren       (ld_ren),
        .prf_rs1_paddr(prf_rs1_paddr),
        .prf_rs1_rdata(prf_rs1_rdata),
        .dmem_addr    (dmem_addr),
        .dmem_rmask   (dmem_rmask),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .cdb_req      (cdb_req),
        .cdb_gnt      (cdb_gnt),
        .cdb_out      (cdb_out),
        .flush        (flush),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic over the load rules.
    function automatic logic [31:0] ref_addr(input logic [31:0] base, input logic [11:0] imm);
        int s;
        s = int'(imm);
        if (s >= 2048) s -= 4096;
        return base + 32'(s);
    endfunction

    function automatic int ref_size(input logic [2:0] f3);
        case (f3)
            F3Lb, F3Lbu: return 1;
            F3Lh, F3Lhu: return 2;
            default:     return 4;
        endcase
    endfunction

    function automatic logic [3:0] ref_mask(input logic [2:0] f3, input int off);
        logic [3:0] m;
        int n;
        n = ref_size(f3);
        for (int b = 0; b < 4; b++) m[b] = (b >= off) && (b < off + n);
        return m;
    endfunction

    function automatic logic [31:0] ref_data(input logic [2:0] f3, input int off,
                                             input logic [31:0] rdata);
        longint w, lim;
        lim = longint'(1) << (8 * ref_size(f3));
        w   = (longint'(rdata) >> (8 * off)) % lim;
        if ((f3 == F3Lb || f3 == F3Lh) && w >= lim / 2) w -= lim;
        return w[31:0];
    endfunction

    function automatic logic ref_misaligned(input logic [2:0] f3, input int off);
        int n;
        n = ref_size(f3);
        return (n == 2 && off % 2 != 0) || (n == 4 && off != 0);
    endfunction

    task automatic run_load(input string tag, input logic [31:0] base, input logic [11:0] imm,
                            input logic [2:0] f3, input logic [5:0] rd, input logic [31:0] rdata,
                            input int d, input int g, input int nr);
        logic [31:0] a, data_e;
        logic [3:0]  mask_e;
        logic [4:0]  rob;
        logic [5:0]  rs;
        logic        exc, done;
        int off, pops, pulses, bcasts, pop_c, mask_c, req_c, bc_c, exp_b;
        a = ref_addr(base, imm);
        off = int'(a[1:0]);
`ifdef LOAD_MISALIGN_CHECK_EN
        exc = ref_misaligned(f3, off);
`else
        exc = 1'b0;
`endif
        mask_e = ref_mask(f3, off);
        data_e = exc ? 32'h0 : ref_data(f3, off, rdata);
        rs  = 6'($urandom_range(1, 63));
        rob = 5'($urandom);
        regfile[rs] = base;
        ld_head.ready = (nr == 0);
        ld_head.rs1_paddr = rs;
        ld_head.rd_paddr = rd;
        ld_head.rob_idx = rob;
        ld_head.funct3 = f3;
        ld_head.imm = imm;
        dmem_rdata = rdata;
        last_mask = 4'h0; last_data = 32'h0; last_addr = 32'h0; last_pkt = '0;
        pops = 0; pulses = 0; bcasts = 0; pop_c = -1; mask_c = -1; req_c = -1; bc_c = -1;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            dmem_resp = 1'b0;
            cdb_gnt = 1'b0;
            if (c == 0) ld_empty = 1'b0;
            if (c == nr) ld_head.ready = 1'b1;
            if (pop_c >= 0 && !busy) begin
                ld_empty = 1'b1;
                done = 1'b1;
            end else begin
                #1;
                if (c == 0) check_eq({tag, "_prf_addr"}, prf_rs1_paddr, rs);
                if (dmem_rmask != 4'h0) begin
                    pulses++;
                    if (mask_c < 0) begin
                        mask_c = c; last_mask = dmem_rmask; last_addr = dmem_addr;
                    end
                end
                if (cdb_req && req_c < 0) req_c = c;
                if (mask_c >= 0 && c == mask_c + d) dmem_resp = 1'b1;
                if (req_c >= 0 && c >= req_c + g) cdb_gnt = 1'b1;
                #1;
                if (ld_ren) begin
                    pops++;
                    if (pop_c < 0) pop_c = c;
                end
                if (cdb_out.cdb_broadcast) begin
                    bcasts++; bc_c = c; last_data = cdb_out.data; last_pkt = cdb_out;
                end
            end
        end
        dmem_resp = 1'b0;
        cdb_gnt = 1'b0;
        check_eq({tag, "_done"}, done, 1'b1);
        check_eq({tag, "_pops"}, pops, 1);
        check_eq({tag, "_pop_cycle"}, pop_c, nr);
        check_eq({tag, "_rmask_pulses"}, pulses, exc ? 0 : 1);
        if (!exc) begin
            check_eq({tag, "_rmask"}, last_mask, mask_e);
            check_eq({tag, "_dmem_addr"}, last_addr, {a[31:2], 2'b00});
            check_eq({tag, "_req_cycle"}, mask_c - pop_c, 1);
        end
        exp_b = (exc || rd != 6'd0) ? 1 : 0;
        check_eq({tag, "_bcasts"}, bcasts, exp_b);
        if (exp_b == 1) begin
            check_eq({tag, "_latency"}, bc_c - pop_c, exc ? 1 + g : 2 + d + g);
            check_eq({tag, "_data"}, last_pkt.data, data_e);
            check_eq({tag, "_p_addr"}, last_pkt.cdb_p_addr, rd);
            check_eq({tag, "_rob"}, last_pkt.rob_idx, rob);
            check_eq({tag, "_exc"}, last_pkt.exc, exc);
        end
    endtask

    task automatic drain(input string tag);
        logic idle;
        idle = 1'b0;
        for (int c = 0; c < 20 && !idle; c++) begin
            @(negedge clk);
            ld_empty = 1'b1;
            if (!busy) begin
                idle = 1'b1;
                dmem_resp = 1'b0; cdb_gnt = 1'b0;
            end else begin
                dmem_resp = 1'b1; cdb_gnt = 1'b1;
            end
        end
        check_eq({tag, "_drain_idle"}, idle, 1'b1);
    endtask

    task automatic run_flush_wait();
        int pop_c, mask_c, pop2, bc;
        logic busy_at;
        pop_c = -1; mask_c = -1; pop2 = -1; bc = 0; busy_at = 1'b1;
        regfile[5] = 32'h2000;
        ld_head.ready = 1'b1; ld_head.rs1_paddr = 6'd5; ld_head.rd_paddr = 6'd7;
        ld_head.rob_idx = 5'd2; ld_head.funct3 = F3Lw; ld_head.imm = 12'h0;
        dmem_rdata = 32'h1234_5678;
        for (int c = 0; c < 30 && pop2 < 0; c++) begin
            @(negedge clk);
            if (c == 0) ld_empty = 1'b0;
            dmem_resp = 1'b0; cdb_gnt = 1'b1; flush = 1'b0;
            if (mask_c >= 0 && c == mask_c + 1) flush = 1'b1;
            if (mask_c >= 0 && c == mask_c + 3) dmem_resp = 1'b1;
            #1;
            if (dmem_rmask != 4'h0 && mask_c < 0) mask_c = c;
            if (cdb_req || cdb_out.cdb_broadcast) bc++;
            if (ld_ren) begin
                if (pop_c < 0) pop_c = c;
                else begin
                    pop2 = c; busy_at = busy;
                end
            end
        end
        flush = 1'b0; dmem_resp = 1'b0; cdb_gnt = 1'b0;
        check_eq("flush_req_cycle", mask_c - pop_c, 1);
        check_eq("flush_no_bcast", bc, 0);
        check_eq("flush_next_pop", pop2 - mask_c, 4);
        check_eq("flush_busy_low", busy_at, 1'b0);
        drain("flush");
    endtask

    task automatic run_reset_mid();
        int bad;
        bad = 0;
        regfile[9] = 32'h3000;
        ld_head.ready = 1'b1; ld_head.rs1_paddr = 6'd9; ld_head.rd_paddr = 6'd4;
        ld_head.rob_idx = 5'd1; ld_head.funct3 = F3Lw; ld_head.imm = 12'h0;
        dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk); ld_empty = 1'b0; #1;
        check_eq("rstmid_pop", ld_ren, 1'b1);
        @(negedge clk); ld_empty = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; dmem_resp = 1'b1; #1;
        check_eq("rstmid_busy", busy, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); dmem_resp = 1'b0; cdb_gnt = 1'b1; #1;
            if (cdb_req || cdb_out.cdb_broadcast || busy) bad++;
        end
        cdb_gnt = 1'b0;
        check_eq("rstmid_ignored_resp", bad, 0);
    endtask

    initial begin
        logic [2:0] f3s [5];
        logic [5:0] rd;
        f3s = '{F3Lb, F3Lh, F3Lw, F3Lbu, F3Lhu};
        for (int i = 0; i < 64; i++) regfile[i] = 32'h0;
        rst = 1'b1; ld_empty = 1'b1; ld_head = '0; dmem_rdata = 32'h0;
        dmem_resp = 1'b0; cdb_gnt = 1'b0; flush = 1'b0;
        repeat (2) @(negedge clk);
        ld_empty = 1'b0; ld_head.ready = 1'b1; cdb_gnt = 1'b1; #1;
        check_eq("rst_ld_ren", ld_ren, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_rmask", dmem_rmask, 4'h0);
        check_eq("rst_cdb_req", cdb_req, 1'b0);
        check_eq("rst_bcast", cdb_out.cdb_broadcast, 1'b0);
        check_eq("rst_p_addr", cdb_out.cdb_p_addr, 6'd0);
        check_eq("rst_data", cdb_out.data, 32'h0);
        @(negedge clk); rst = 1'b0; flush = 1'b1; #1;
        check_eq("flush_idle_no_pop", ld_ren, 1'b0);
        @(negedge clk); flush = 1'b0; ld_empty = 1'b1; cdb_gnt = 1'b0;

        run_load("lw_basic", 32'h1000, 12'h004, F3Lw, 6'd10, 32'hDEAD_BEEF, 1, 0, 0);
        check_eq("lw_basic_const_data", last_data, 32'hDEAD_BEEF);
        check_eq("lw_basic_const_addr", last_addr, 32'h1004);
        check_eq("lw_basic_const_mask", last_mask, 4'hF);
        run_load("lb", 32'h1000, 12'h003, F3Lb, 6'd11, 32'h80FF_FFFF, 0, 1, 0);
        check_eq("lb_const_mask", last_mask, 4'h8);
        check_eq("lb_const_data", last_data, 32'hFFFF_FF80);
        run_load("lbu", 32'h1000, 12'h003, F3Lbu, 6'd12, 32'h80FF_FFFF, 1, 0, 0);
        check_eq("lbu_const_data", last_data, 32'h0000_0080);
        run_load("slow", 32'h2000, 12'h008, F3Lw, 6'd13, 32'h0BAD_F00D, 5, 3, 0);
        run_load("not_ready", 32'h2000, 12'h010, F3Lh, 6'd14, 32'h0000_8001, 2, 0, 10);
        run_load("rd_zero", 32'h3000, 12'h000, F3Lw, 6'd0, 32'h5555_AAAA, 1, 0, 0);
        run_load("neg_imm", 32'h0000_0010, 12'hFFC, F3Lw, 6'd15, 32'h0102_0304, 2, 1, 0);
        run_load("wrap", 32'hFFFF_FFFE, 12'h004, F3Lbu, 6'd16, 32'h00AB_0000, 1, 0, 0);
        run_load("lw_misalign", 32'h1000, 12'h002, F3Lw, 6'd17, 32'hA1B2_C3D4, 1, 0, 0);
`ifdef LOAD_MISALIGN_CHECK_EN
        check_eq("lw_misalign_exc", last_pkt.exc, 1'b1);
`else
        check_eq("lw_misalign_const_mask", last_mask, 4'hC);
`endif
        run_flush_wait();
        run_reset_mid();

        for (int i = 0; i < 24; i++) begin
            rd = (($urandom % 8) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            run_load($sformatf("rand%0d", i), $urandom, 12'($urandom), f3s[$urandom_range(0, 4)],
                     rd, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
